// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared timing constants for the traffic controller blocks
package traffic_pkg;

    // Default number of consecutive disagreeing edges before a debounced level moves
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Default debounce counter width (2**CNT_W must exceed the debounce length)
    localparam int CNT_W_DEFAULT = 4;

    // Smallest counter width able to hold the values 0 .. cycles-1
    function automatic int cnt_w_min(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_debounce_edge.sv
// rtl/input_debounce_edge.sv - single-channel debounce counter with rising-edge detect
module input_debounce_edge
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing edges; any agreeing edge restarts the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (raw_in != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = raw_in;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, its one-edge-old copy and the counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level_out = stable_q;
    // Combinational rise; the parent registers it so pulses land one edge after the level moves
    assign rise_out  = stable_q & ~prev_q;

endmodule

// File: rtl/traffic_input_conditioner.sv
// rtl/traffic_input_conditioner.sv - debounced levels, edge pulses and sticky walk request
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic walkRequest_syn_in,
    input  logic reprogram_syn_in,
    input  logic sensor_syn_in,
    input  logic walkRequest_clear_in,
    output logic walkRequest_pending_out,
    output logic reprogram_pulse_out,
    output logic sensor_level_out,
    output logic sensor_rise_out
);

    logic walk_rise;
    logic reprogram_rise;
    logic sensor_rise;
    logic sensor_level;
    logic walk_level_unused;
    logic reprogram_level_unused;

    logic walk_pending_q;
    logic walk_pending_d;
    logic reprogram_pulse_q;
    logic sensor_rise_q;

    input_debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_walk (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (walkRequest_syn_in),
        .level_out (walk_level_unused),
        .rise_out  (walk_rise)
    );

    input_debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reprogram (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (reprogram_syn_in),
        .level_out (reprogram_level_unused),
        .rise_out  (reprogram_rise)
    );

    input_debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sensor (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (sensor_syn_in),
        .level_out (sensor_level),
        .rise_out  (sensor_rise)
    );

    // Walk latch: a new rise beats a coincident acknowledge so no request is lost
    always_comb begin
        walk_pending_d = walk_rise | (walk_pending_q & ~walkRequest_clear_in);
    end

    // Output registers for the walk flag and the one-cycle pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            walk_pending_q    <= 1'b0;
            reprogram_pulse_q <= 1'b0;
            sensor_rise_q     <= 1'b0;
        end else begin
            walk_pending_q    <= walk_pending_d;
            reprogram_pulse_q <= reprogram_rise;
            sensor_rise_q     <= sensor_rise;
        end
    end

    assign walkRequest_pending_out = walk_pending_q;
    assign reprogram_pulse_out     = reprogram_pulse_q;
    assign sensor_level_out        = sensor_level;
    assign sensor_rise_out         = sensor_rise_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb/tb_traffic_input_conditioner.sv - randomized and directed check against a behavioural model
module tb_traffic_input_conditioner;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic walk_i;
    logic rep_i;
    logic sens_i;
    logic clr_i;
    logic pend_o;
    logic rep_o;
    logic slvl_o;
    logic srise_o;

    int total = 0;
    int bad   = 0;

    // Model state: debounced level per channel, previous level, recent raw history
    bit        m_s    [3];
    bit        m_prev [3];
    bit [15:0] m_hist [3];
    bit        e_pend;
    bit        e_rep;
    bit        e_srise;

    always #5 clk = ~clk;

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .walkRequest_syn_in      (walk_i),
        .reprogram_syn_in        (rep_i),
        .sensor_syn_in           (sens_i),
        .walkRequest_clear_in    (clr_i),
        .walkRequest_pending_out (pend_o),
        .reprogram_pulse_out     (rep_o),
        .sensor_level_out        (slvl_o),
        .sensor_rise_out         (srise_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_s[c]    = 1'b0;
            m_prev[c] = 1'b0;
            m_hist[c] = '0;
        end
        e_pend  = 1'b0;
        e_rep   = 1'b0;
        e_srise = 1'b0;
    endtask

    // One clock edge: the level moves once the last DB raw samples all disagree with it;
    // pulses and the walk flag follow from the level before the edge
    task automatic model_edge(input bit w, input bit r, input bit s, input bit clr);
        bit raw  [3];
        bit rise [3];
        bit all_diff;
        raw[0] = w;
        raw[1] = r;
        raw[2] = s;
        for (int c = 0; c < 3; c++) rise[c] = m_s[c] && !m_prev[c];
        e_pend  = rise[0] || (e_pend && !clr);
        e_rep   = rise[1];
        e_srise = rise[2];
        for (int c = 0; c < 3; c++) begin
            m_prev[c] = m_s[c];
            m_hist[c] = {m_hist[c][14:0], raw[c]};
            all_diff  = 1'b1;
            for (int k = 0; k < DB; k++) if (m_hist[c][k] == m_s[c]) all_diff = 1'b0;
            if (all_diff) m_s[c] = raw[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(walk_i, rep_i, sens_i, clr_i);
        #1;
        check("pend", pend_o, e_pend);
        check("rep_pulse", rep_o, e_rep);
        check("sens_lvl", slvl_o, m_s[2]);
        check("sens_rise", srise_o, e_srise);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_pend", pend_o, 0);
        check("rst_async_rep", rep_o, 0);
        check("rst_async_lvl", slvl_o, 0);
        check("rst_async_rise", srise_o, 0);
        @(posedge clk);
        #1;
        check("rst_hold_lvl", slvl_o, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int n_rise;
        int n_rep;
        reset_n = 1'b0;
        walk_i  = 1'b0;
        rep_i   = 1'b0;
        sens_i  = 1'b0;
        clr_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pend", pend_o, 0);
        check("reset_rep", rep_o, 0);
        check("reset_lvl", slvl_o, 0);
        check("reset_rise", srise_o, 0);
        reset_n = 1'b1;

        // Sensor held high: level after 4 edges, one pulse only
        sens_i = 1'b1;
        n_rise = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 3) check("t1_lvl_edge4", slvl_o, 1);
            n_rise += int'(srise_o);
        end
        check("t1_pulse_count", n_rise, 1);

        // Sensor falls: no pulse on the fall
        sens_i = 1'b0;
        n_rise = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) check("t6_lvl_fall", slvl_o, 0);
            n_rise += int'(srise_o);
        end
        check("t6_no_fall_pulse", n_rise, 0);

        // Walk glitch of 3 cycles is rejected, 4 cycles latches
        walk_i = 1'b1;
        repeat (3) tick();
        walk_i = 1'b0;
        repeat (4) tick();
        check("t2_glitch", pend_o, 0);
        walk_i = 1'b1;
        repeat (4) tick();
        walk_i = 1'b0;
        tick();
        check("t2_latched", pend_o, 1);
        repeat (6) tick();
        check("t2_sticky", pend_o, 1);

        // Clear coincident with a new rise keeps the flag, then a lone clear drops it
        walk_i = 1'b1;
        repeat (4) tick();
        clr_i = 1'b1;
        tick();
        check("t3_set_wins", pend_o, 1);
        clr_i = 1'b0;
        tick();
        clr_i = 1'b1;
        tick();
        check("t3_cleared", pend_o, 0);
        tick();
        check("t3_clear_idle", pend_o, 0);
        clr_i  = 1'b0;
        walk_i = 1'b0;
        repeat (5) tick();

        // Reprogram 1,0,1,1,1,1 then held: one pulse, 5 edges after the final rise
        n_rep = 0;
        rep_i = 1'b1; tick(); n_rep += int'(rep_o);
        rep_i = 1'b0; tick(); n_rep += int'(rep_o);
        rep_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_rep += int'(rep_o);
            if (i == 4) check("t4_no_early", rep_o, 0);
            if (i == 5) check("t4_pulse_edge5", rep_o, 1);
        end
        check("t4_pulse_count", n_rep, 1);
        rep_i = 1'b0;
        repeat (5) tick();

        // All high, reset at count 2, full debounce again after release
        walk_i = 1'b1;
        rep_i  = 1'b1;
        sens_i = 1'b1;
        repeat (2) tick();
        async_reset();
        n_rep  = 0;
        n_rise = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_rep  += int'(rep_o);
            n_rise += int'(srise_o);
            if (i == 4) check("t5_pend_wait", pend_o, 0);
            if (i == 5) check("t5_pend_set", pend_o, 1);
        end
        check("t5_rep_count", n_rep, 1);
        check("t5_rise_count", n_rise, 1);

        // Random phase: slowly changing levels, occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) walk_i = ~walk_i;
            if ($urandom_range(0, 4) == 0) rep_i  = ~rep_i;
            if ($urandom_range(0, 4) == 0) sens_i = ~sens_i;
            clr_i = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 399) == 0) async_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
